// File: rtl/brief_matcher.sv
// brief_matcher: brute-force Hamming matcher between the current frame's BRIEF
// features and the previous frame's stored features. Features are written into
// a ping-pong bank pair; queries wait in a small FIFO and are scanned one
// reference per cycle against the bank that is not being written.
// Optional feature macro: BRIEF_MATCHER_RATIO_EN adds a best/second-best ratio
// test (4*best <= 3*second) on top of the absolute distance threshold.
module brief_matcher #(
  parameter int DEPTH        = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int MATCH_THRESH = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_frame_start,
  input  logic         i_flag,
  input  logic [9:0]   i_coor_x,
  input  logic [9:0]   i_coor_y,
  input  logic [255:0] i_descriptor,
  input  logic [7:0]   i_score,
  output logic         o_match_valid,
  output logic [9:0]   o_src_x,
  output logic [9:0]   o_src_y,
  output logic [9:0]   o_dst_x,
  output logic [9:0]   o_dst_y,
  output logic [8:0]   o_distance,
  output logic         o_busy,
  output logic         o_drop
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DEPTH);
  localparam logic [FCNT_W-1:0] FIFO_FULL_C = FCNT_W'(FIFO_DEPTH);
  localparam logic [8:0]        THRESH_C    = 9'(MATCH_THRESH);
  localparam logic [8:0]        DIST_MAX_C  = 9'd256;

  typedef struct packed {
    logic [9:0]   x;
    logic [9:0]   y;
    logic [255:0] desc;
    logic [7:0]   score;
  } feat_t;

  typedef struct packed {
    logic [9:0]   x;
    logic [9:0]   y;
    logic [255:0] desc;
  } query_t;

  // State   | meaning
  // S_IDLE  | waiting for a queued query; pops (and drops it if no refs exist)
  // S_SCAN  | comparing the query against one reference entry per cycle
  // S_EMIT  | scan finished; publish result if it passes the acceptance test
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_EMIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  feat_t             r_bank [2][DEPTH];
  logic              r_bank_sel;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_ref_cnt;

  query_t            r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [FCNT_W-1:0] r_fifo_cnt;

  query_t            r_query;
  logic [IDX_W-1:0]  r_idx;
  logic [8:0]        r_best;
  logic [9:0]        r_best_x;
  logic [9:0]        r_best_y;
`ifdef BRIEF_MATCHER_RATIO_EN
  logic [8:0]        r_second;
`endif

  logic              r_match_valid;
  logic [9:0]        r_src_x;
  logic [9:0]        r_src_y;
  logic [9:0]        r_dst_x;
  logic [9:0]        r_dst_y;
  logic [8:0]        r_distance;
  logic              r_drop;

  logic              w_wr_bank;
  logic [IDX_W-1:0]  w_wr_addr;
  logic              w_store;
  feat_t             w_feat;
  logic              w_fifo_full;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_push_addr;
  feat_t             w_ref;
  logic [255:0]      w_xor;
  logic [8:0]        w_dist;
  logic              w_last;
  logic              w_accept;
  logic              w_unused_score;

  // A feature arriving with frame_start belongs to the new frame, so it goes
  // to entry 0 of the bank that becomes the write bank at this edge.
  assign w_wr_bank   = i_frame_start ? ~r_bank_sel : r_bank_sel;
  assign w_wr_addr   = i_frame_start ? '0 : r_wr_cnt[IDX_W-1:0];
  assign w_store     = i_flag && (i_frame_start || (r_wr_cnt < DEPTH_C));
  assign w_feat      = '{x: i_coor_x, y: i_coor_y, desc: i_descriptor, score: i_score};

  assign w_fifo_full = (r_fifo_cnt == FIFO_FULL_C);
  assign w_push      = i_flag && (i_frame_start || !w_fifo_full);
  assign w_pop       = (r_state == S_IDLE) && (r_fifo_cnt != '0) && !i_frame_start;
  assign w_push_addr = i_frame_start ? '0 : r_wr_ptr;

  // Reference reads always target the bank not being written this frame.
  assign w_ref          = r_bank[~r_bank_sel][r_idx];
  assign w_xor          = r_query.desc ^ w_ref.desc;
  assign w_unused_score = ^w_ref.score;
  assign w_last         = (CNT_W'(r_idx) == (r_ref_cnt - CNT_W'(1)));

`ifdef BRIEF_MATCHER_RATIO_EN
  logic [10:0] w_best_x4;
  logic [10:0] w_second_x3;
  assign w_best_x4   = {r_best, 2'b00};
  assign w_second_x3 = {2'b00, r_second} + {1'b0, r_second, 1'b0};
  assign w_accept    = (r_best <= THRESH_C) && (w_best_x4 <= w_second_x3);
`else
  assign w_accept    = (r_best <= THRESH_C);
`endif

  // Popcount of the XOR gives the Hamming distance for the current ref entry.
  always_comb begin
    w_dist = '0;
    for (int i = 0; i < 256; i++) begin
      w_dist = w_dist + {8'd0, w_xor[i]};
    end
  end

  // Feature bank storage; contents need no reset since ref_cnt gates reads.
  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_bank[w_wr_bank][w_wr_addr] <= w_feat;
    end
  end

  // Bank select and per-frame write/reference counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank_sel <= 1'b0;
      r_wr_cnt   <= '0;
      r_ref_cnt  <= '0;
    end else if (i_frame_start) begin
      r_bank_sel <= ~r_bank_sel;
      r_ref_cnt  <= r_wr_cnt;
      r_wr_cnt   <= i_flag ? CNT_W'(1) : '0;
    end else if (i_flag && (r_wr_cnt < DEPTH_C)) begin
      r_wr_cnt   <= r_wr_cnt + CNT_W'(1);
    end
  end

  // Query FIFO payload storage.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[w_push_addr] <= '{x: i_coor_x, y: i_coor_y, desc: i_descriptor};
    end
  end

  // Query FIFO pointers and occupancy; frame_start flushes before the push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else if (i_frame_start) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= i_flag ? PTR_W'(1) : '0;
      r_fifo_cnt <= i_flag ? FCNT_W'(1) : '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + FCNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - FCNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; frame_start aborts whatever is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if ((r_fifo_cnt != '0) && (r_ref_cnt != '0)) w_state_nxt = S_SCAN;
      S_SCAN:  if (w_last) w_state_nxt = S_EMIT;
      S_EMIT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_frame_start) w_state_nxt = S_IDLE;
  end

  // Query capture and running best (strict < keeps the lowest index on ties).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_query  <= '0;
      r_idx    <= '0;
      r_best   <= DIST_MAX_C;
      r_best_x <= '0;
      r_best_y <= '0;
`ifdef BRIEF_MATCHER_RATIO_EN
      r_second <= DIST_MAX_C;
`endif
    end else if (w_pop) begin
      r_query  <= r_fifo[r_rd_ptr];
      r_idx    <= '0;
      r_best   <= DIST_MAX_C;
`ifdef BRIEF_MATCHER_RATIO_EN
      r_second <= DIST_MAX_C;
`endif
    end else if (r_state == S_SCAN) begin
      r_idx <= r_idx + IDX_W'(1);
      if (w_dist < r_best) begin
        r_best   <= w_dist;
        r_best_x <= w_ref.x;
        r_best_y <= w_ref.y;
`ifdef BRIEF_MATCHER_RATIO_EN
        r_second <= r_best;
`endif
      end
`ifdef BRIEF_MATCHER_RATIO_EN
      else if (w_dist < r_second) begin
        r_second <= w_dist;
      end
`endif
    end
  end

  // Result outputs hold between pulses; drop flags a query lost to a full FIFO.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_match_valid <= 1'b0;
      r_src_x       <= '0;
      r_src_y       <= '0;
      r_dst_x       <= '0;
      r_dst_y       <= '0;
      r_distance    <= '0;
      r_drop        <= 1'b0;
    end else begin
      r_match_valid <= 1'b0;
      r_drop        <= i_flag && !i_frame_start && w_fifo_full;
      if ((r_state == S_EMIT) && !i_frame_start && w_accept) begin
        r_match_valid <= 1'b1;
        r_src_x       <= r_query.x;
        r_src_y       <= r_query.y;
        r_dst_x       <= r_best_x;
        r_dst_y       <= r_best_y;
        r_distance    <= r_best;
      end
    end
  end

  assign o_match_valid = r_match_valid;
  assign o_src_x       = r_src_x;
  assign o_src_y       = r_src_y;
  assign o_dst_x       = r_dst_x;
  assign o_dst_y       = r_dst_y;
  assign o_distance    = r_distance;
  assign o_drop        = r_drop;
  assign o_busy        = (r_fifo_cnt != '0) || (r_state != S_IDLE);

endmodule
